rgb_cmd_ctrl: RTL

RGB_CMD_CTRL -- requirements
Module: rgb_cmd_ctrl

---
 rtl/rgb_cmd_pkg.sv | 31 +++
 rtl/rgb_echo_buf.sv | 54 +++++
 rtl/rgb_cmd_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rgb_cmd_pkg.sv
// rgb_cmd_pkg
// Shared definitions for the RGB command controller: the command-parser
// state encoding, the ASCII byte values the grammar is built from, and a
// small digit classifier.
// Build option: RGB_ECHO_EN (used by rgb_cmd_ctrl) enables the UART echo path.
package rgb_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_R_VAL,
    S_G_TAG,
    S_G_VAL,
    S_B_TAG,
    S_B_VAL,
    S_EOL,
    S_ERR
  } state_e;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_G  = 8'h47;
  localparam logic [7:0] ASCII_B  = 8'h42;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/rgb_echo_buf.sv
// rgb_echo_buf
// One-entry byte buffer that feeds received bytes back to a UART
// transmitter. A byte is offered on out_valid/out_data and held stable
// until the out_valid && out_ready cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid, in_data   byte to echo (one-cycle strobe)
//   out_ready           transmitter accepts a byte this cycle
//   out_valid, out_data byte offered to the transmitter
//   empty               buffer holds no byte
module rgb_echo_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       empty
);

  logic       full_q, full_d;
  logic [7:0] data_q, data_d;
  logic       drain;

  always_comb begin
    drain  = full_q && out_ready;
    full_d = full_q;
    data_d = data_q;
    // A byte arriving while the buffer is full and not draining is dropped;
    // a byte arriving in the draining cycle replaces it with no bubble.
    if (in_valid && (!full_q || drain)) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= 8'h00;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign empty     = !full_q;

endmodule

// File: rtl/rgb_cmd_ctrl.sv
// rgb_cmd_ctrl
// Parses "R<d>G<d>B<d>\n" commands arriving as UART bytes and drives three
// PWM duty values. Each digit is scaled by DUTY_STEP (saturating at the
// duty width). The three duties change together, only when a complete,
// well-formed command is terminated by LF. CR bytes are ignored anywhere.
// Build option: define RGB_ECHO_EN to echo every received byte back through
// a one-entry buffer (rgb_echo_buf); otherwise tx_valid/tx_data are tied 0.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   rx_valid, rx_data                received byte strobe and value
//   tx_ready                         transmitter can accept the echo byte
//   tx_valid, tx_data                echo byte offered to the transmitter
//   duty_red/green/blue              duty values to the PWM generators
//   done                             idle with no echo byte pending
//   cmd_ok, cmd_err                  one-cycle command applied / rejected
module rgb_cmd_ctrl
  import rgb_cmd_pkg::*;
#(
  parameter int DUTY_W    = 8,
  parameter int DUTY_STEP = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic [DUTY_W-1:0] duty_red,
  output logic [DUTY_W-1:0] duty_green,
  output logic [DUTY_W-1:0] duty_blue,
  output logic              done,
  output logic              cmd_ok,
  output logic              cmd_err
);

  // Product is formed wide enough that a 4-bit digit times a 32-bit step
  // never wraps before the saturation compare.
  localparam int PROD_W = (DUTY_W > 36) ? DUTY_W + 1 : 37;

  function automatic logic [DUTY_W-1:0] scale_digit(input logic [3:0] d);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(d) * PROD_W'(DUTY_STEP);
    if (prod > PROD_W'({DUTY_W{1'b1}}))
      return '1;
    else
      return prod[DUTY_W-1:0];
  endfunction

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] shadow_r_q, shadow_r_d;
  logic [DUTY_W-1:0] shadow_g_q, shadow_g_d;
  logic [DUTY_W-1:0] shadow_b_q, shadow_b_d;
  logic [DUTY_W-1:0] duty_r_q, duty_r_d;
  logic [DUTY_W-1:0] duty_g_q, duty_g_d;
  logic [DUTY_W-1:0] duty_b_q, duty_b_d;
  logic              cmd_ok_q, cmd_ok_d;
  logic              cmd_err_q, cmd_err_d;

  logic              byte_is_lf;
  logic              byte_is_digit;
  logic [DUTY_W-1:0] byte_duty;

  always_comb begin
    byte_is_lf    = (rx_data == ASCII_LF);
    byte_is_digit = is_digit(rx_data);
    // '0'..'9' are 8'h30..8'h39, so the low nibble is the digit value.
    byte_duty     = scale_digit(rx_data[3:0]);

    state_d    = state_q;
    shadow_r_d = shadow_r_q;
    shadow_g_d = shadow_g_q;
    shadow_b_d = shadow_b_q;
    duty_r_d   = duty_r_q;
    duty_g_d   = duty_g_q;
    duty_b_d   = duty_b_q;
    cmd_ok_d   = 1'b0;
    cmd_err_d  = 1'b0;

    if (rx_valid && (rx_data != ASCII_CR)) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == ASCII_R) begin
            state_d = S_R_VAL;
          end else if (!byte_is_lf) begin
            state_d   = S_ERR;
            cmd_err_d = 1'b1;
          end
        end

        S_R_VAL, S_G_VAL, S_B_VAL: begin
          if (byte_is_digit) begin
            case (state_q)
              S_R_VAL: begin shadow_r_d = byte_duty; state_d = S_G_TAG; end
              S_G_VAL: begin shadow_g_d = byte_duty; state_d = S_B_TAG; end
              default: begin shadow_b_d = byte_duty; state_d = S_EOL;   end
            endcase
          end else begin
            // An early LF already ends the line, so there is nothing left
            // to discard: go straight back to idle.
            cmd_err_d = 1'b1;
            state_d   = byte_is_lf ? S_IDLE : S_ERR;
          end
        end

        S_G_TAG, S_B_TAG: begin
          if ((state_q == S_G_TAG) && (rx_data == ASCII_G)) begin
            state_d = S_G_VAL;
          end else if ((state_q == S_B_TAG) && (rx_data == ASCII_B)) begin
            state_d = S_B_VAL;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = byte_is_lf ? S_IDLE : S_ERR;
          end
        end

        S_EOL: begin
          if (byte_is_lf) begin
            duty_r_d = shadow_r_q;
            duty_g_d = shadow_g_q;
            duty_b_d = shadow_b_q;
            cmd_ok_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = S_ERR;
          end
        end

        S_ERR: begin
          if (byte_is_lf)
            state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shadow_r_q <= '0;
      shadow_g_q <= '0;
      shadow_b_q <= '0;
      duty_r_q   <= '0;
      duty_g_q   <= '0;
      duty_b_q   <= '0;
      cmd_ok_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_r_q <= shadow_r_d;
      shadow_g_q <= shadow_g_d;
      shadow_b_q <= shadow_b_d;
      duty_r_q   <= duty_r_d;
      duty_g_q   <= duty_g_d;
      duty_b_q   <= duty_b_d;
      cmd_ok_q   <= cmd_ok_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  assign duty_red   = duty_r_q;
  assign duty_green = duty_g_q;
  assign duty_blue  = duty_b_q;
  assign cmd_ok     = cmd_ok_q;
  assign cmd_err    = cmd_err_q;

`ifdef RGB_ECHO_EN
  logic echo_empty;

  // Every byte is echoed, including CR and bytes the parser rejects.
  rgb_echo_buf u_echo_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rx_valid),
    .in_data   (rx_data),
    .out_ready (tx_ready),
    .out_valid (tx_valid),
    .out_data  (tx_data),
    .empty     (echo_empty)
  );

  assign done = (state_q == S_IDLE) && echo_empty;
`else
  logic unused_tx_ready;

  assign unused_tx_ready = tx_ready;
  assign tx_valid        = 1'b0;
  assign tx_data         = 8'h00;
  assign done            = (state_q == S_IDLE);
`endif

endmodule
